// File: rtl/bitwise_pkg.sv
// bitwise_pkg: op encoding and stage payload shared by the bitwise pipeline
package bitwise_pkg;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {OP_XOR, OP_XNOR, OP_AND, OP_OR} op_e;
  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             zero;
    logic             par;
  } payload_t;
endpackage

// File: rtl/bitwise_pipe_stage.sv
// bitwise_pipe_stage: one elastic register slot holding a valid bit and payload
module bitwise_pipe_stage
  import bitwise_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     up_valid,
  input  payload_t up_data,
  input  logic     down_ready,
  output logic     valid,
  output payload_t data
);
  logic     load;
  logic     valid_d, valid_q;
  payload_t data_d, data_q;
  always_comb begin
    load    = !valid_q || down_ready;
    valid_d = load ? up_valid : valid_q;
    data_d  = load && up_valid ? up_data : data_q;
  end
  always_ff @(posedge clk) begin
    valid_q <= reset ? 1'b0 : valid_d;
    data_q  <= reset ? '0 : data_d;
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/bitwise_pipe.sv
// bitwise_pipe: elastic pipeline applying a selectable bitwise op to two operands
module bitwise_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      txn_count
);
  op_e              opc;
  logic [WIDTH-1:0] res;
  payload_t         in_pl;
  payload_t         pl [DEPTH];
  logic [DEPTH-1:0] vld, adv;
  logic             rdy;
  logic [15:0]      txn_d, txn_q;
  always_comb begin
    opc   = op_e'(op);
    res   = opc == OP_XOR ? a ^ b : opc == OP_XNOR ? ~(a ^ b) : opc == OP_AND ? a & b : a | b;
    in_pl = '{res: MAX_W'(res), zero: res == '0, par: ^res};
    adv   = '0;
    rdy   = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = rdy;
      rdy    = rdy || !vld[k];
    end
    txn_d = out_valid && out_ready ? txn_q + 16'd1 : txn_q;
  end
  always_ff @(posedge clk) txn_q <= reset ? '0 : txn_d;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic     up_v;
    payload_t up_d;
    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_pl;
    end else begin : g_body
      assign up_v = vld[k-1];
      assign up_d = pl[k-1];
    end
    bitwise_pipe_stage u_stage (
      .clk       (clk),
      .reset     (reset),
      .up_valid  (up_v),
      .up_data   (up_d),
      .down_ready(adv[k]),
      .valid     (vld[k]),
      .data      (pl[k])
    );
  end
  if (WIDTH < MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^pl[DEPTH-1].res[MAX_W-1:WIDTH];
  end
  assign in_ready  = rdy && !reset;
  assign out_valid = vld[DEPTH-1];
  assign y         = pl[DEPTH-1].res[WIDTH-1:0];
  assign y_zero    = pl[DEPTH-1].zero;
  assign y_parity  = pl[DEPTH-1].par;
  assign txn_count = txn_q;
endmodule

// File: tb/tb_bitwise_pipe.sv
// tb_bitwise_pipe: directed and randomized scoreboard bench for bitwise_pipe
module tb_bitwise_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  typedef struct {
    logic [WIDTH-1:0] y;
    logic             z;
    logic             p;
    int               t;
  } item_t;
  logic             clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [WIDTH-1:0] a = 0, b = 0;
  logic [1:0]       op = 0;
  logic             in_ready, y_zero, y_parity, out_valid;
  logic [WIDTH-1:0] y;
  logic [15:0]      txn_count;
  int               n_tests = 0, n_fail = 0, cyc_n = 0, acc_n = 0, dut_acc = 0, ntx = 0;
  item_t            exp_q[$];
  logic [WIDTH-1:0] got_y[$];
  int               got_c[$];
  logic [7:0]       sweep [4] = '{8'h5A, 8'hA5, 8'hA0, 8'hFA};

  bitwise_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .y        (y),
    .y_zero   (y_zero),
    .y_parity (y_parity),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc_n);
    end
  endtask

  function automatic item_t ref_op(input logic [WIDTH-1:0] x, w, input logic [1:0] o, input int t);
    item_t it;
    case (o)
      2'd0:    it.y = x ^ w;
      2'd1:    it.y = ~(x ^ w);
      2'd2:    it.y = x & w;
      default: it.y = x | w;
    endcase
    it.z = (it.y == 0);
    it.p = ($countones(it.y) % 2) == 1;
    it.t = t;
    return it;
  endfunction

  // An item sits at the output exactly DEPTH cycles after it was presented,
  // since nothing older can be ahead of the oldest item.
  task automatic tick(input logic iv, input logic [WIDTH-1:0] ia, ib, input logic [1:0] iop, input logic ordy);
    logic exp_ov, exp_ir;
    in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
    #1;
    if (iv && in_ready) dut_acc++;
    if (reset) check("rst_in_ready", in_ready, 0);
    else begin
      exp_ir = exp_q.size() < DEPTH || ordy;
      exp_ov = exp_q.size() > 0 && cyc_n >= exp_q[0].t + DEPTH;
      check("in_ready", in_ready, exp_ir);
      check("out_valid", out_valid, exp_ov);
      if (out_valid && ordy) begin
        got_y.push_back(y);
        got_c.push_back(cyc_n);
      end
      if (exp_ov) begin
        check("y", y, exp_q[0].y);
        check("y_zero", y_zero, exp_q[0].z);
        check("y_parity", y_parity, exp_q[0].p);
        if (ordy) begin
          void'(exp_q.pop_front());
          ntx++;
        end
      end
      if (iv && exp_ir) begin
        exp_q.push_back(ref_op(ia, ib, iop, cyc_n));
        acc_n++;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (reset) begin
      exp_q.delete();
      ntx = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_txn", txn_count, 0);
    check("rst_hold_in_ready", in_ready, 0);
    reset = 0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    got_y.delete();
    got_c.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [1:0]       ro;
    do_reset();
    tick(1, 8'h3C, 8'h0F, 2'd0, 1);
    tick(0, 0, 0, 0, 1);
    check("lat_ov", out_valid, 1);
    check("lat_y", y, 8'h33);
    check("lat_z", y_zero, 0);
    check("lat_p", y_parity, 0);
    tick(0, 0, 0, 0, 1);
    check("lat_txn", txn_count, 1);

    got_y.delete();
    got_c.delete();
    for (int i = 0; i < 4; i++) tick(1, 8'hF0, 8'hAA, 2'(i), 1);
    repeat (3) tick(0, 0, 0, 0, 1);
    check("sweep_n", got_y.size(), 4);
    for (int i = 0; i < 4 && i < got_y.size(); i++) begin
      check($sformatf("sweep_y%0d", i), got_y[i], sweep[i]);
      check($sformatf("sweep_cyc%0d", i), got_c[i] - got_c[0], i);
    end

    do_reset();
    dut_acc = 0;
    for (int i = 0; i < 3; i++) tick(1, 8'(i * 37 + 5), 8'h5A, 2'd3, 0);
    check("bp_acc", dut_acc, 2);
    check("bp_in_ready", in_ready, 0);
    tick(1, 8'(2 * 37 + 5), 8'h5A, 2'd3, 1);
    check("bp_acc3", dut_acc, 3);
    repeat (4) tick(0, 0, 0, 0, 1);
    check("bp_n", got_y.size(), 3);
    check("bp_txn", txn_count, 3);

    tick(1, 8'h12, 8'h34, 2'd2, 0);
    tick(1, 8'h56, 8'h78, 2'd1, 0);
    reset = 1;
    tick(0, 0, 0, 0, 1);
    reset = 0;
    got_y.delete();
    repeat (4) tick(0, 0, 0, 0, 1);
    check("mf_out", got_y.size(), 0);
    check("mf_txn", txn_count, 0);

    do_reset();
    acc_n = 0;
    for (int g = 0; g < 3000 && acc_n < 120; g++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 2'($urandom);
      if ($urandom_range(7) == 0) begin
        rb = ra;
        ro = 2'd0;
      end
      tick($urandom_range(3) != 0, ra, rb, ro, $urandom_range(2) != 0);
    end
    check("rnd_acc", acc_n, 120);
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) tick(0, 0, 0, 0, 1);
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_txn", txn_count, 32'(ntx[15:0]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc_n);
    $fatal(1);
  end
endmodule

// File: doc/bitwise_pipe.md
BITWISE_PIPE -- requirements
Module: bitwise_pipe

Interface
- REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 1..32.
- REQ-002 Parameter DEPTH, default 2: number of pipeline register stages; legal range 1..4.
- REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004 Port reset, input, 1: synchronous, active-high reset.
- REQ-005 Port in_valid, input, 1: an operand pair is presented.
- REQ-006 Port in_ready, output, 1: the pipeline accepts the pair this cycle.
- REQ-007 Port a, input, WIDTH: operand A.
- REQ-008 Port b, input, WIDTH: operand B.
- REQ-009 Port op, input, 2: operation select. 0 = XOR, 1 = XNOR, 2 = AND, 3 = OR.
- REQ-010 Port y, output, WIDTH: result.
- REQ-011 Port y_zero, output, 1: result equals 0.
- REQ-012 Port y_parity, output, 1: XOR-reduction of y.
- REQ-013 Port out_valid, output, 1: y, y_zero and y_parity are valid.
- REQ-014 Port out_ready, input, 1: the consumer takes the result this cycle.
- REQ-015 Port txn_count, output, 16: number of completed output transfers.

Function
- REQ-016 The block shall accept an input when in_valid && in_ready at a rising edge.
- REQ-017 The block shall complete an output transfer when out_valid && out_ready at a rising edge.
- REQ-018 The result shall be computed combinationally from a, b and op at acceptance and captured into stage 0 together with y_zero and y_parity; op shall not affect data already in flight.
- REQ-019 Stage k shall hold a valid bit plus the captured result, zero flag and parity; stage DEPTH-1 shall drive y, y_zero, y_parity and out_valid directly from registers.
- REQ-020 Stage k shall load from stage k-1 (stage 0 from the input) when stage k is empty or stage k is advancing in the same cycle.
- REQ-021 Bubbles shall collapse: an empty stage shall never block an upstream stage.
- REQ-022 in_ready shall be combinational: true when stage 0 is empty or stage 0 advances this cycle.
- REQ-023 Latency shall be DEPTH cycles from acceptance to out_valid when out_ready is held high.
- REQ-024 With out_ready held high, throughput shall be one result per cycle.
- REQ-025 While out_valid && !out_ready, y, y_zero and y_parity shall hold stable.
- REQ-026 Results shall leave in acceptance order; none shall be dropped or duplicated.
- REQ-027 A full pipeline holds DEPTH results; while it is full and stalled, in_ready shall be 0.
- REQ-028 Simultaneous acceptance and output transfer on a full pipeline shall shift all stages and capture the new pair in the same cycle.
- REQ-029 txn_count shall increment by 1 on each output transfer and shall wrap from 0xFFFF to 0.
- REQ-030 When in_valid is 0, a, b and op shall be ignored.

Reset
- REQ-031 When reset is high at a rising edge, all stage valid bits shall clear to 0, and y, y_zero, y_parity and txn_count shall clear to 0.
- REQ-032 While reset is high, in_ready shall be 0 and no input shall be accepted.
- REQ-033 Reset asserted mid-operation shall discard all in-flight results, with no output transfer in that cycle.
- REQ-034 out_valid shall first be able to rise DEPTH cycles after the first acceptance following reset release.

Structure
- REQ-035 A shared package bitwise_pkg shall define:
  - an op enum type: OP_XOR, OP_XNOR, OP_AND, OP_OR;
  - the stage payload struct type, parameterised by WIDTH (result, zero flag, parity).
- REQ-036 One pipeline stage, holding the valid bit, payload and load/advance logic, shall be a sub-module named bitwise_pipe_stage, instantiated DEPTH times by a generate loop.

Verification
- REQ-037 Reset scenario, WIDTH=8, DEPTH=2: after reset with no input, out_valid, y and txn_count shall be 0 and in_ready shall be 1 after release.
- REQ-038 Latency scenario: accept a=0x3C, b=0x0F, op=XOR with out_ready=1. At cycle +2, out_valid=1, y=0x33, y_zero=0 and y_parity=0.
- REQ-039 Op-sweep scenario: send a=0xF0, b=0xAA back-to-back with op 0..3. Outputs shall be 0x5A, 0xA5, 0xA0, 0xFA on consecutive cycles.
- REQ-040 Backpressure scenario: hold out_ready=0 and stream 3 inputs.
  - 2 shall be accepted and in_ready shall drop to 0.
  - After out_ready=1, all 3 shall emerge in order and txn_count shall be 3.
- REQ-041 Mid-flight reset scenario: pulse reset for 1 cycle with 2 results in flight. No result shall emerge, and txn_count shall be 0.
- REQ-042 Random scenario: 120 random transactions against a reference model with random out_ready. All results shall match, and y_zero shall be checked on a=b with op=XOR.
